// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath front end.
//   state_t : operand-loader FSM encoding (S_A=0, S_B=1, S_VALID=2)
//   DIGIT_W : width of one hex digit in bits
package calc_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/operand_loader_nibble_shift_reg.sv
// nibble_shift_reg: accumulates hex digits into a WIDTH-bit register,
// most significant digit first, and counts how many have been taken.
// Once WIDTH/4 digits are held it reports full_o and ignores shifts.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   clr_i         : synchronous clear of value and count
//   shift_en_i    : shift nib_i into the low nibble (ignored when full)
//   nib_i         : digit to shift in
//   q_o           : accumulated value (registered)
//   full_o        : digit count has reached WIDTH/4
module nibble_shift_reg
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               clr_i,
  input  logic               shift_en_i,
  input  logic [DIGIT_W-1:0] nib_i,
  output logic [WIDTH-1:0]   q_o,
  output logic               full_o
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_next;
  logic             w_full;

  // A single-digit operand has nothing to shift up, so the slice is skipped.
  generate
    if (WIDTH == DIGIT_W) begin : g_single
      assign w_next = nib_i;
    end else begin : g_multi
      assign w_next = {r_q[WIDTH-DIGIT_W-1:0], nib_i};
    end
  endgenerate

  assign w_full = (r_cnt == N_CNT);

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (shift_en_i && !w_full) begin
      r_q   <= w_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign q_o    = r_q;
  assign full_o = w_full;

endmodule

// File: rtl/operand_loader.sv
// operand_loader: builds operands A then B from a serial hex-digit stream
// and presents them to the adder with a valid/ack handshake.
//   clk_i, rstn_i        : clock, synchronous active-low reset
//   digit_valid_i/digit_i: one hex digit per cycle when valid
//   enter_i              : commit operand being entered (A -> B -> valid)
//   clear_i              : abort and zero everything
//   ack_i                : downstream consumed the pair (only in S_VALID)
//   a_o, b_o             : operands to the adder
//   valid_o              : a_o/b_o complete and held stable
//   cur_o                : operand being entered (b_o while valid)
//   sel_b_o              : 0 entering A, 1 entering B or valid
//   err_o                : sticky too-many-digits flag
//
// Handshake: valid_o rises once B is entered and stays high, with a_o/b_o
// frozen, until the cycle ack_i is sampled high; on the following edge the
// pair is dropped and entry of a new A starts. ack_i is ignored otherwise.
module operand_loader
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               digit_valid_i,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               enter_i,
  input  logic               clear_i,
  input  logic               ack_i,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               valid_o,
  output logic [WIDTH-1:0]   cur_o,
  output logic               sel_b_o,
  output logic               err_o
);

  state_t r_state;
  logic   r_valid;
  logic   r_sel_b;
  logic   r_err;

  logic   w_shift_a;
  logic   w_shift_b;
  logic   w_clr;
  logic   w_full_a;
  logic   w_full_b;

  // clear_i outranks everything; ack_i only drops the pair in S_VALID.
  assign w_clr     = clear_i || (ack_i && (r_state == S_VALID));
  assign w_shift_a = !clear_i && digit_valid_i && (r_state == S_A);
  assign w_shift_b = !clear_i && digit_valid_i && (r_state == S_B);

  nibble_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (w_clr),
    .shift_en_i (w_shift_a),
    .nib_i      (digit_i),
    .q_o        (a_o),
    .full_o     (w_full_a)
  );

  nibble_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (w_clr),
    .shift_en_i (w_shift_b),
    .nib_i      (digit_i),
    .q_o        (b_o),
    .full_o     (w_full_b)
  );

  // Digit and enter in the same cycle both land on one edge: the shift
  // register takes the digit while the state moves on.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clear_i) begin
      r_state <= S_A;
      r_valid <= 1'b0;
      r_sel_b <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          if (digit_valid_i && w_full_a) r_err <= 1'b1;
          if (enter_i) begin
            r_state <= S_B;
            r_sel_b <= 1'b1;
          end
        end
        S_B: begin
          if (digit_valid_i && w_full_b) r_err <= 1'b1;
          if (enter_i) begin
            r_state <= S_VALID;
            r_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (ack_i) begin
            r_state <= S_A;
            r_valid <= 1'b0;
            r_sel_b <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_A;
          r_valid <= 1'b0;
          r_sel_b <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = r_valid;
  assign sel_b_o = r_sel_b;
  assign err_o   = r_err;
  // sel_b is high in both S_B and S_VALID, so B is shown in both.
  assign cur_o   = r_sel_b ? b_o : a_o;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

  localparam int W  = 8;
  localparam int N  = W / 4;
  localparam int SW = 3 * W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn_i = 1'b0;
  logic         digit_valid_i = 1'b0;
  logic [3:0]   digit_i = 4'h0;
  logic         enter_i = 1'b0;
  logic         clear_i = 1'b0;
  logic         ack_i = 1'b0;
  logic [W-1:0] a_o, b_o, cur_o;
  logic         valid_o, sel_b_o, err_o;

  operand_loader #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .digit_valid_i (digit_valid_i),
    .digit_i       (digit_i),
    .enter_i       (enter_i),
    .clear_i       (clear_i),
    .ack_i         (ack_i),
    .a_o           (a_o),
    .b_o           (b_o),
    .valid_o       (valid_o),
    .cur_o         (cur_o),
    .sel_b_o       (sel_b_o),
    .err_o         (err_o)
  );

  // ---------------- reference model ----------------
  // phase 0: typing A, 1: typing B, 2: pair ready
  int m_phase, m_a, m_b, m_na, m_nb;
  bit m_err;

  int total = 0;
  int bad = 0;
  logic [SW-1:0] exp_q[$];

  function automatic void model_zero();
    m_phase = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit rn, bit dv, int d, bit en, bit clr, bit ack);
    if (!rn || clr) begin
      model_zero();
    end else if (m_phase == 2) begin
      if (ack) model_zero();
    end else begin
      if (dv) begin
        if (m_phase == 0) begin
          if (m_na < N) begin m_a = m_a * 16 + d; m_na++; end
          else m_err = 1;
        end else begin
          if (m_nb < N) begin m_b = m_b * 16 + d; m_nb++; end
          else m_err = 1;
        end
      end
      if (en) m_phase++;
    end
  endfunction

  function automatic logic [SW-1:0] model_snap();
    logic [W-1:0] ea, eb, ec;
    ea = W'(m_a);
    eb = W'(m_b);
    ec = (m_phase == 0) ? ea : eb;
    return {ea, eb, ec, (m_phase == 2), (m_phase != 0), m_err};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rn, input bit dv, input logic [3:0] d,
                      input bit en, input bit clr, input bit ack);
    @(negedge clk);
    rstn_i = rn; digit_valid_i = dv; digit_i = d;
    enter_i = en; clear_i = clr; ack_i = ack;
    @(posedge clk);
    model_step(rn, dv, int'(d), en, clr, ack);
    exp_q.push_back(model_snap());
  endtask

  task automatic idle();
    step(1, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic dig(input logic [3:0] d);
    step(1, 1, d, 0, 0, 0);
  endtask

  task automatic ent();
    step(1, 0, 4'h0, 1, 0, 0);
  endtask

  task automatic check(input string name, input int got, input int exp);
    @(negedge clk);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [SW-1:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {a_o, b_o, cur_o, valid_o, sel_b_o, err_o};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got a=%h b=%h cur=%h v=%b s=%b e=%b exp a=%h b=%h cur=%h v=%b s=%b e=%b",
                   $time, g[SW-1 -: W], g[2*W+2 -: W], g[W+2 -: W], g[2], g[1], g[0],
                   e[SW-1 -: W], e[2*W+2 -: W], e[W+2 -: W], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_zero();
    step(0, 0, 4'h0, 0, 0, 0);
    step(0, 1, 4'h5, 1, 0, 0);

    // normal entry: 3A + 05
    dig(4'h3); dig(4'hA); ent(); dig(4'h0); dig(4'h5); ent();
    check("sum_3a_05", int'({1'b0, a_o} + {1'b0, b_o}), 'h03F);
    step(1, 0, 4'h0, 0, 0, 1);
    idle();

    // overflow on A, err sticks through B, cleared by ack
    dig(4'h1); dig(4'h2); dig(4'h3); ent(); dig(4'h4); ent(); idle();
    step(1, 0, 4'h0, 0, 0, 1);

    // same-cycle digit + enter
    dig(4'h7); step(1, 1, 4'h9, 1, 0, 0);
    dig(4'h2); ent(); step(1, 0, 4'h0, 0, 0, 1);

    // stability in S_VALID with FF + 01
    dig(4'hF); dig(4'hF); ent(); dig(4'h0); dig(4'h1); ent();
    dig(4'h6); ent(); step(1, 1, 4'hC, 1, 0, 0); step(1, 0, 4'h0, 0, 0, 0);
    check("sum_ff_01", int'({1'b0, a_o} + {1'b0, b_o}), 'h100);

    // reset pulse between edges must do nothing
    idle();
    #2 rstn_i = 1'b0;
    #2 rstn_i = 1'b1;
    check("valid_after_glitch", int'(valid_o), 1);
    // synchronous reset while valid
    step(0, 0, 4'h0, 0, 0, 0);
    idle();

    // clear mid-entry of B with a digit
    dig(4'h1); ent(); dig(4'h4); step(1, 1, 4'h8, 0, 1, 0); idle();

    // ack outside S_VALID is ignored; empty operands commit as 0
    dig(4'h6); step(1, 0, 4'h0, 0, 0, 1); ent(); ent(); idle();
    step(1, 0, 4'h0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) == 0));
    end
    idle();

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream input stage of the calculator datapath.
- Assembles two WIDTH-bit operands from a serial stream of 4-bit hex digits, such as those from a keypad decoder.
- Presents the operands on registered outputs that drive `full_adder_nbits` `a_i`/`b_i` directly.
- Uses a valid/ack handshake so the downstream result stage can capture the sum before the next entry begins.

Parameters:
- WIDTH, 8, operand width in bits.
  - Must be a multiple of 4 and at least 4.
  - Equals the `width` parameter of the downstream adder.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rstn_i  input  1  synchronous reset, active low.
- digit_valid_i  input  1  digit_i carries a new digit this cycle.
- digit_i  input  4  hex digit, value 0x0 to 0xF.
- enter_i  input  1  commits the operand currently being entered.
- clear_i  input  1  aborts entry and zeroes everything.
- ack_i  input  1  downstream has consumed the operand pair.
- a_o  output  WIDTH  operand A; connects to adder a_i.
- b_o  output  WIDTH  operand B; connects to adder b_i.
- valid_o  output  1  a_o and b_o are complete and stable.
- cur_o  output  WIDTH  operand currently being entered, for display.
- sel_b_o  output  1  0 = entering A, 1 = entering B.
- err_o  output  1  sticky digit-overflow flag.

Behaviour:
- Reset:
  - rstn_i=0 at a clock edge sets state S_A.
  - All outputs go to 0: a_o, b_o, cur_o, valid_o, sel_b_o, err_o.
  - Digit counter goes to 0.
  - Reset has the highest priority, including in the middle of entry or while valid_o=1.
- States and outputs:
  - S_A: sel_b_o=0, valid_o=0.
  - S_B: sel_b_o=1, valid_o=0.
  - S_VALID: sel_b_o=1, valid_o=1.
- Digit load, only in S_A or S_B:
  - Active operand becomes {operand[WIDTH-5:0], digit_i}.
  - Digit count increments.
  - Takes effect on the next edge, so latency is 1 cycle.
- Digit limit (N = WIDTH/4):
  - When count==N, a further digit is ignored: operand unchanged, count unchanged.
  - err_o is set to 1 and stays set until clear_i, reset, or ack_i.
- cur_o:
  - Equals a_o in S_A and b_o in S_B.
  - In S_VALID it holds b_o.
- Enter:
  - In S_A: go to S_B and reset the count to 0.
  - In S_B: go to S_VALID.
  - In S_VALID: ignored.
  - An empty operand is legal and commits as 0.
- Digit and enter in the same cycle, in S_A or S_B: the digit is loaded first, then the state advances. Both take effect on the same edge.
- S_VALID:
  - digit_valid_i and enter_i are ignored.
  - a_o and b_o are held stable for the whole period valid_o=1.
- ack_i:
  - Acts only in S_VALID.
  - Next edge: state S_A, a_o=b_o=0, count 0, err_o=0, valid_o=0.
  - ack_i outside S_VALID is ignored.
- clear_i:
  - In any state, the next edge applies the reset values.
  - Priority order: rstn_i, then clear_i, then ack_i, then enter_i, then digit_valid_i. A digit or enter arriving in the same cycle as clear_i is dropped.
- General rules:
  - All outputs are registered; there is no combinational path from input to output.
  - No arithmetic is performed beyond the shift and the count; the digit count width is $clog2(N+1).

Decomposition:
- Shared package calc_pkg contains:
  - the 2-bit state enum: S_A=0, S_B=1, S_VALID=2;
  - the constant DIGIT_W=4.
- One sub-module, nibble_shift_reg:
  - Parameter WIDTH.
  - Inputs: clk_i, rstn_i, clr_i, shift_en_i, nib_i.
  - Outputs: q_o and full_o.
  - Instantiated twice, once for A and once for B.
- The top level holds the FSM, the err flag, and the output muxing.

Test Plan:
- Normal entry, WIDTH=8:
  - Stimulus: digits 3, A, then enter; digits 0, 5, then enter.
  - Required: valid_o=1 one cycle after the second enter, a_o=0x3A, b_o=0x05, and the adder s_o=0x3F with cout_o=0.
  - Then ack_i=1 for one cycle gives valid_o=0, a_o=b_o=0, sel_b_o=0 on the next cycle.
- Overflow:
  - Stimulus: in S_A, digits 1, 2, 3.
  - Required: a_o=0x12 and err_o=1 after the third digit.
  - err_o stays 1 through the enter of B and clears on ack_i.
- Same-cycle digit and enter:
  - Stimulus: in S_A after digit 7, apply digit 9 with enter_i in the same cycle.
  - Required: a_o=0x79 and sel_b_o=1 on the same edge.
- Stability under ignored inputs:
  - Stimulus: in S_VALID with a_o=0xFF, b_o=0x01, apply digits and enter_i.
  - Required: outputs unchanged; the adder shows s_o=0x00, cout_o=1.
- Clear mid-entry:
  - Stimulus: in S_B with b_o=0x04, assert clear_i together with digit 8.
  - Required: next cycle S_A, a_o=b_o=cur_o=0, err_o=0.
- Reset:
  - Stimulus: rstn_i=0 for one edge while valid_o=1.
  - Required: every output is 0 after that edge; asynchronous deassertion between edges has no effect.
